pipe_phy_ctrl: RTL and testbench

PIPE PHY power-state and receiver-detect sequencer sitting between the LTSSM logic and the PHY-side PIPE control pins. It runs the PhyStatus handshakes for PHY reset release, PowerDown changes and receiver detection, so the LTSSM only issues level-held requests and waits for acknowledge pulses. It owns o_PowerDown, o_TxDetectRx and o_TxElecIdle for one lane.

---
 rtl/pipe_phy_ctrl_if.sv | 30 +++
 rtl/pipe_phy_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_phy_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_phy_ctrl_if.sv
// LTSSM/PHY-facing control bundle for one lane of the PIPE power/detect sequencer.
// The master side is the LTSSM plus PHY status pins; the slave side is the sequencer.
interface pipe_phy_ctrl_if;
  logic       i_PhyStatus;
  logic [2:0] i_RxStatus;
  logic       i_DetReq;
  logic       i_PwrReq;
  logic [1:0] i_PwrState;
  logic       o_DetDone;
  logic       o_DetResult;
  logic       o_PwrAck;
  logic       o_Timeout;
  logic       o_PhyReady;
  logic       o_Busy;
  logic [1:0] o_PowerDown;
  logic       o_TxDetectRx;
  logic       o_TxElecIdle;

  modport master (
    output i_PhyStatus, i_RxStatus, i_DetReq, i_PwrReq, i_PwrState,
    input  o_DetDone, o_DetResult, o_PwrAck, o_Timeout, o_PhyReady, o_Busy,
    input  o_PowerDown, o_TxDetectRx, o_TxElecIdle
  );

  modport slave (
    input  i_PhyStatus, i_RxStatus, i_DetReq, i_PwrReq, i_PwrState,
    output o_DetDone, o_DetResult, o_PwrAck, o_Timeout, o_PhyReady, o_Busy,
    output o_PowerDown, o_TxDetectRx, o_TxElecIdle
  );
endinterface

// File: rtl/pipe_phy_ctrl.sv
// PIPE PHY power-state and receiver-detect sequencer. Runs the PhyStatus handshakes for
// PHY reset release, PowerDown changes and receiver detection; all outputs are registered.
module pipe_phy_ctrl #(
  parameter int unsigned PHYSTATUS_TIMEOUT = 1024,
  parameter int unsigned CNT_W             = 11
) (
  input logic            i_PCLK,
  input logic            i_Reset,
  pipe_phy_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StRstWait,
    StIdle,
    StPwrPrep,
    StPwrWait,
    StDetect,
    StDonePwr,
    StDoneDet,
    StRel
  } state_e;

  localparam logic [1:0]       PdP0       = 2'b00;
  localparam logic [1:0]       PdP1       = 2'b10;
  localparam logic [2:0]       RxDetected = 3'b011;
  localparam logic [CNT_W-1:0] CntLast    = CNT_W'(PHYSTATUS_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       power_down_q, power_down_d;
  logic             tx_det_q, tx_det_d;
  logic             elec_idle_q, elec_idle_d;
  logic             det_result_q, det_result_d;
  logic             det_done_q, det_done_d;
  logic             pwr_ack_q, pwr_ack_d;
  logic             timeout_q, timeout_d;
  logic             phy_ready_q, phy_ready_d;
  logic             busy_q, busy_d;
  logic             served_pwr_q, served_pwr_d;
  logic             cnt_clr;
  logic             counting;
  logic             tmo_hit;

  assign tmo_hit = (cnt_q == CntLast);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    power_down_d = power_down_q;
    tx_det_d     = tx_det_q;
    elec_idle_d  = elec_idle_q;
    det_result_d = det_result_q;
    phy_ready_d  = phy_ready_q;
    served_pwr_d = served_pwr_q;
    det_done_d   = 1'b0;
    pwr_ack_d    = 1'b0;
    timeout_d    = 1'b0;
    cnt_clr      = 1'b0;

    unique case (state_q)
      StRstWait: begin
        if (!bus.i_PhyStatus) begin
          state_d     = StIdle;
          phy_ready_d = 1'b1;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      StIdle: begin
        // Power requests win over detect; a losing detect stays pending at the requester.
        if (bus.i_PwrReq) begin
          served_pwr_d = 1'b1;
          if (bus.i_PwrState == power_down_q) begin
            state_d     = StDonePwr;
            pwr_ack_d   = 1'b1;
            elec_idle_d = (power_down_q != PdP0);
          end else if (power_down_q == PdP0) begin
            state_d     = StPwrPrep;
            elec_idle_d = 1'b1;
          end else begin
            state_d      = StPwrWait;
            power_down_d = bus.i_PwrState;
          end
        end else if (bus.i_DetReq) begin
          served_pwr_d = 1'b0;
          if (power_down_q == PdP1) begin
            state_d     = StDetect;
            tx_det_d    = 1'b1;
            elec_idle_d = 1'b1;
          end else begin
            state_d      = StDoneDet;
            det_done_d   = 1'b1;
            det_result_d = 1'b0;
          end
        end
      end
      StPwrPrep: begin
        // Electrical idle has been asserted for one cycle before the PowerDown change.
        state_d      = StPwrWait;
        power_down_d = bus.i_PwrState;
      end
      StPwrWait: begin
        if (bus.i_PhyStatus || tmo_hit) begin
          state_d     = StDonePwr;
          pwr_ack_d   = 1'b1;
          timeout_d   = !bus.i_PhyStatus;
          elec_idle_d = (power_down_q != PdP0);
        end
      end
      StDetect: begin
        if (bus.i_PhyStatus) begin
          state_d      = StDoneDet;
          det_done_d   = 1'b1;
          det_result_d = (bus.i_RxStatus == RxDetected);
          tx_det_d     = 1'b0;
        end else if (tmo_hit) begin
          state_d      = StDoneDet;
          det_done_d   = 1'b1;
          det_result_d = 1'b0;
          tx_det_d     = 1'b0;
          timeout_d    = 1'b1;
        end
      end
      StDonePwr: state_d = StRel;
      StDoneDet: state_d = StRel;
      StRel: begin
        // Release on the served request only, so a pending losing detect is not deadlocked.
        if (served_pwr_q ? !bus.i_PwrReq : !bus.i_DetReq) begin
          state_d = StIdle;
        end
      end
      default: state_d = StRstWait;
    endcase

    busy_d   = (state_d != StIdle);
    counting = (state_q == StRstWait) || (state_q == StPwrWait) || (state_q == StDetect);
    if (cnt_clr || !counting || (state_d != state_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_PCLK or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= StRstWait;
      cnt_q        <= '0;
      power_down_q <= PdP1;
      tx_det_q     <= 1'b0;
      elec_idle_q  <= 1'b1;
      det_result_q <= 1'b0;
      det_done_q   <= 1'b0;
      pwr_ack_q    <= 1'b0;
      timeout_q    <= 1'b0;
      phy_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      served_pwr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      power_down_q <= power_down_d;
      tx_det_q     <= tx_det_d;
      elec_idle_q  <= elec_idle_d;
      det_result_q <= det_result_d;
      det_done_q   <= det_done_d;
      pwr_ack_q    <= pwr_ack_d;
      timeout_q    <= timeout_d;
      phy_ready_q  <= phy_ready_d;
      busy_q       <= busy_d;
      served_pwr_q <= served_pwr_d;
    end
  end

  assign bus.o_DetDone    = det_done_q;
  assign bus.o_DetResult  = det_result_q;
  assign bus.o_PwrAck     = pwr_ack_q;
  assign bus.o_Timeout    = timeout_q;
  assign bus.o_PhyReady   = phy_ready_q;
  assign bus.o_Busy       = busy_q;
  assign bus.o_PowerDown  = power_down_q;
  assign bus.o_TxDetectRx = tx_det_q;
  assign bus.o_TxElecIdle = elec_idle_q;

endmodule

// File: tb/tb_pipe_phy_ctrl.sv
// Scoreboard bench for pipe_phy_ctrl: stimulus queues expected completion events, a monitor
// checks every DetDone/PwrAck/Timeout pulse against the queue.
module tb_pipe_phy_ctrl;
  localparam int unsigned TMO = 24;
  localparam int unsigned CW  = 5;

  logic clk;
  logic rst;
  pipe_phy_ctrl_if bus ();

  pipe_phy_ctrl #(
    .PHYSTATUS_TIMEOUT(TMO),
    .CNT_W            (CW)
  ) dut (
    .i_PCLK (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;  // 0 detect done, 1 power ack, 2 timeout
    logic       res;
    logic [1:0] pd;
    logic       eidle;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_det(input logic res);
    exp_q.push_back('{kind: 0, res: res, pd: 2'b00, eidle: 1'b0});
  endtask

  task automatic push_pwr(input logic [1:0] pd);
    exp_q.push_back('{kind: 1, res: 1'b0, pd: pd, eidle: (pd != 2'b00)});
  endtask

  task automatic push_tmo();
    exp_q.push_back('{kind: 2, res: 1'b0, pd: 2'b00, eidle: 1'b0});
  endtask

  task automatic check_ev(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == 0) chk("det_result", int'(bus.o_DetResult), int'(e.res));
      if (kind == 1) begin
        chk("ack_powerdown", int'(bus.o_PowerDown), int'(e.pd));
        chk("ack_elecidle", int'(bus.o_TxElecIdle), int'(e.eidle));
      end
    end
  endtask

  // Monitor: compare each completion pulse against the scoreboard.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (bus.o_Timeout) check_ev(2);
      if (bus.o_DetDone) check_ev(0);
      if (bus.o_PwrAck)  check_ev(1);
    end
  end

  function automatic logic hit(input int which);
    case (which)
      0:       return bus.o_DetDone;
      1:       return bus.o_PwrAck;
      2:       return !bus.o_Busy;
      default: return bus.o_PhyReady;
    endcase
  endfunction

  // Bounded wait, sampled on negedges; n returns the number of negedges waited.
  task automatic wait_for(input int which, input int max_cyc, input string name, output int n);
    int i = 0;
    while (!hit(which) && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    n = i;
    checks++;
    if (!hit(which)) begin
      errors++;
      $display("FAIL %s: event absent after %0d cycles, expected it", name, max_cyc);
    end
  endtask

  task automatic run_det(input logic [2:0] rx, input int dly, input logic res);
    int n;
    @(negedge clk);
    bus.i_DetReq = 1'b1;
    push_det(res);
    @(negedge clk);
    chk("txdet_rise", int'(bus.o_TxDetectRx), 1);
    chk("det_elecidle", int'(bus.o_TxElecIdle), 1);
    repeat (dly - 1) @(negedge clk);
    bus.i_PhyStatus = 1'b1;
    bus.i_RxStatus  = rx;
    @(negedge clk);
    bus.i_PhyStatus = 1'b0;
    bus.i_RxStatus  = 3'b000;
    chk("txdet_fall", int'(bus.o_TxDetectRx), 0);
    wait_for(0, 4, "det_done", n);
    bus.i_DetReq = 1'b0;
    wait_for(2, 4, "det_idle", n);
  endtask

  task automatic run_pwr(input logic [1:0] tgt, input int dly, input bit prep, input bit hs);
    int n;
    @(negedge clk);
    bus.i_PwrReq   = 1'b1;
    bus.i_PwrState = tgt;
    push_pwr(tgt);
    if (prep) begin
      @(negedge clk);
      chk("prep_elecidle", int'(bus.o_TxElecIdle), 1);
      chk("prep_pd_held", int'(bus.o_PowerDown), 0);
    end
    if (hs) begin
      @(negedge clk);
      chk("pd_load", int'(bus.o_PowerDown), int'(tgt));
      repeat (dly - 1) @(negedge clk);
      bus.i_PhyStatus = 1'b1;
      @(negedge clk);
      bus.i_PhyStatus = 1'b0;
    end
    wait_for(1, 8, "pwr_ack", n);
    bus.i_PwrReq = 1'b0;
    wait_for(2, 4, "pwr_idle", n);
  endtask

  initial begin
    int n;
    bit txbad;
    rst             = 1'b1;
    bus.i_PhyStatus = 1'b1;
    bus.i_RxStatus  = 3'b000;
    bus.i_DetReq    = 1'b0;
    bus.i_PwrReq    = 1'b0;
    bus.i_PwrState  = 2'b10;
    repeat (3) @(negedge clk);
    chk("rst_pd", int'(bus.o_PowerDown), 2);
    chk("rst_elecidle", int'(bus.o_TxElecIdle), 1);
    chk("rst_txdet", int'(bus.o_TxDetectRx), 0);
    chk("rst_ready", int'(bus.o_PhyReady), 0);
    chk("rst_busy", int'(bus.o_Busy), 1);
    chk("rst_pulses", int'({bus.o_DetDone, bus.o_PwrAck, bus.o_Timeout, bus.o_DetResult}), 0);

    // PHY holds PhyStatus for 20 cycles after reset release.
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("ready_while_phystatus", int'(bus.o_PhyReady), 0);
    bus.i_PhyStatus = 1'b0;
    wait_for(3, 2, "phy_ready", n);
    @(negedge clk);
    chk("ready_pd", int'(bus.o_PowerDown), 2);
    chk("ready_elecidle", int'(bus.o_TxElecIdle), 1);
    chk("ready_busy", int'(bus.o_Busy), 0);

    run_det(3'b011, 8, 1'b1);
    run_det(3'b000, 8, 1'b0);

    run_pwr(2'b00, 5, 1'b0, 1'b1);
    chk("p0_elecidle", int'(bus.o_TxElecIdle), 0);
    run_pwr(2'b10, 5, 1'b1, 1'b1);

    // Simultaneous detect and power-to-P0: power first, then detect is rejected in P0.
    @(negedge clk);
    bus.i_DetReq   = 1'b1;
    bus.i_PwrReq   = 1'b1;
    bus.i_PwrState = 2'b00;
    push_pwr(2'b00);
    push_det(1'b0);
    @(negedge clk);
    chk("combo_pd", int'(bus.o_PowerDown), 0);
    chk("combo_txdet", int'(bus.o_TxDetectRx), 0);
    repeat (4) @(negedge clk);
    bus.i_PhyStatus = 1'b1;
    @(negedge clk);
    bus.i_PhyStatus = 1'b0;
    wait_for(1, 8, "combo_ack", n);
    bus.i_PwrReq = 1'b0;
    txbad = 1'b0;
    n     = 0;
    while (!bus.o_DetDone && n < 10) begin
      if (bus.o_TxDetectRx) txbad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("combo_det_done", int'(bus.o_DetDone), 1);
    chk("combo_txdet_never", int'(txbad), 0);
    bus.i_DetReq = 1'b0;
    wait_for(2, 4, "combo_idle", n);

    run_pwr(2'b10, 5, 1'b1, 1'b1);
    // Same-state request acknowledges without a PHY handshake.
    run_pwr(2'b10, 0, 1'b0, 1'b0);

    // Detect with a silent PHY times out.
    @(negedge clk);
    bus.i_DetReq = 1'b1;
    push_tmo();
    push_det(1'b0);
    wait_for(0, TMO + 5, "det_timeout", n);
    chk("det_timeout_latency", n, TMO + 1);
    chk("det_timeout_txdet", int'(bus.o_TxDetectRx), 0);
    bus.i_DetReq = 1'b0;
    wait_for(2, 4, "tmo_idle", n);

    // Asynchronous reset in the middle of PWR_WAIT.
    @(negedge clk);
    bus.i_PwrReq   = 1'b1;
    bus.i_PwrState = 2'b11;
    repeat (3) @(negedge clk);
    chk("pwrwait_pd", int'(bus.o_PowerDown), 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_pwr_pd", int'(bus.o_PowerDown), 2);
    chk("arst_pwr_busy", int'(bus.o_Busy), 1);
    chk("arst_pwr_ready", int'(bus.o_PhyReady), 0);
    chk("arst_pwr_ack", int'(bus.o_PwrAck), 0);
    bus.i_PwrReq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_for(3, 3, "ready_after_arst1", n);

    // Asynchronous reset in the middle of DETECT.
    @(negedge clk);
    bus.i_DetReq = 1'b1;
    repeat (3) @(negedge clk);
    chk("detect_txdet", int'(bus.o_TxDetectRx), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_det_txdet", int'(bus.o_TxDetectRx), 0);
    chk("arst_det_elecidle", int'(bus.o_TxElecIdle), 1);
    chk("arst_det_done", int'(bus.o_DetDone), 0);
    chk("arst_det_busy", int'(bus.o_Busy), 1);
    bus.i_DetReq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_for(3, 3, "ready_after_arst2", n);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
